// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with hardwired-zero x0, optional
// write-to-read bypass, pending-write scoreboard and a post-reset clear sequencer.
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   output logic [NREG-1:0]     busy_vec,
   output logic                ready
);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   localparam bit USE_BYPASS = (BYPASS != 0);
   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   state_t              state;
   state_t              stateNext;
   logic [AW-1:0]       idx;
   logic [AW-1:0]       idxNext;
   logic [NREG-1:0]     busyVec;
   logic [NREG-1:0]     busyNext;
   logic                memWe;
   logic [AW-1:0]       memAddr;
   logic [XLEN-1:0]     memData;
   logic                isReady;
   logic                wrValid;
   logic                rsvValid;

   // x0 has no storage; entry 0 is never allocated
   logic [XLEN-1:0]     regs [1:NREG-1];

   assign isReady  = (state == READY);
   assign wrValid  = isReady && wr_en && (wr_addr != '0);
   assign rsvValid = isReady && rsv_en && (rsv_addr != '0);

   // NOTE: state and scoreboard use non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= CLEAR;
         idx     <= AW'(1);
         busyVec <= '0;
      end else begin
         state   <= stateNext;
         idx     <= idxNext;
         busyVec <= busyNext;
      end
   end

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      stateNext = state;
      idxNext   = idx;
      memWe     = 1'b0;
      memAddr   = wr_addr;
      memData   = wr_data;
      case (state)
         CLEAR: begin
            memWe   = 1'b1;
            memAddr = idx;
            memData = '0;
            idxNext = idx + AW'(1);
            if (idx == LAST_IDX) stateNext = READY;
         end
         READY: begin
            memWe = wrValid;
         end
         default: stateNext = CLEAR;
      endcase
   end

   // Write clears the pending bit, a same-cycle reservation then sets it again
   always_comb begin
      busyNext = busyVec;
      if (wrValid)  busyNext[wr_addr]  = 1'b0;
      if (rsvValid) busyNext[rsv_addr] = 1'b1;
      busyNext[0] = 1'b0;
   end

   // NOTE: the array is deliberately not reset so it can map onto RAM; the
   // CLEAR sequencer zeroes it instead, one entry per cycle.
   always_ff @(posedge clk) begin
      if (memWe) regs[memAddr] <= memData;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;

      assign addr = rs_addr[k*AW +: AW];
      assign hit  = USE_BYPASS && wrValid && (wr_addr == addr);

      assign rd_data[k*XLEN +: XLEN] = (!isReady || addr == '0) ? '0
                                     : hit                      ? wr_data
                                     :                            regs[addr];
      assign rs_busy[k] = isReady && !hit && busyVec[addr];
   end

   assign busy_vec = busyVec;
   assign ready    = isReady;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default config with and without bypass,
// plus a 64-bit, 16-entry, 3-read-port instance.
module tb_regfile_mp;

   localparam int AWA = 5;
   localparam int AWC = 4;

   typedef struct {
      string       name;
      logic [63:0] exp;
   } exp_t;

   exp_t        expQ[$];
   logic [63:0] actQ[$];
   int          vectors     = 0;
   int          miscompares = 0;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // A (bypass) and B (no bypass) share stimulus
   logic [2*AWA-1:0] rsAddr;
   logic             wrEn;
   logic [AWA-1:0]   wrAddr;
   logic [31:0]      wrData;
   logic             rsvEn;
   logic [AWA-1:0]   rsvAddr;
   logic [63:0]      rdA, rdB;
   logic [1:0]       rsBusyA, rsBusyB;
   logic [31:0]      busyA, busyB;
   logic             readyA, readyB;

   logic [3*AWC-1:0] rsAddrC;
   logic             wrEnC;
   logic [AWC-1:0]   wrAddrC;
   logic [63:0]      wrDataC;
   logic             rsvEnC;
   logic [AWC-1:0]   rsvAddrC;
   logic [191:0]     rdC;
   logic [2:0]       rsBusyC;
   logic [15:0]      busyC;
   logic             readyC;

   regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dutA (
      .clk(clk), .reset_n(reset_n), .rs_addr(rsAddr), .rd_data(rdA), .rs_busy(rsBusyA),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
      .busy_vec(busyA), .ready(readyA));

   regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dutB (
      .clk(clk), .reset_n(reset_n), .rs_addr(rsAddr), .rd_data(rdB), .rs_busy(rsBusyB),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
      .busy_vec(busyB), .ready(readyB));

   regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(1)) dutC (
      .clk(clk), .reset_n(reset_n), .rs_addr(rsAddrC), .rd_data(rdC), .rs_busy(rsBusyC),
      .wr_en(wrEnC), .wr_addr(wrAddrC), .wr_data(wrDataC), .rsv_en(rsvEnC), .rsv_addr(rsvAddrC),
      .busy_vec(busyC), .ready(readyC));

   task automatic expect_val(input string n, input logic [63:0] v);
      expQ.push_back('{name: n, exp: v});
   endtask

   task automatic idle_inputs();
      wrEn = 1'b0; wrAddr = '0; wrData = '0; rsvEn = 1'b0; rsvAddr = '0;
      wrEnC = 1'b0; wrAddrC = '0; wrDataC = '0; rsvEnC = 1'b0; rsvAddrC = '0;
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [63:0] a;
      idle_inputs();
      rsAddr  = {5'd4, 5'd3};
      rsAddrC = {4'd3, 4'd2, 4'd1};
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      expect_val("rst_readyA", 64'd0);   expect_val("rst_readyC", 64'd0);
      expect_val("rst_busyA", 64'd0);    expect_val("rst_rdA", 64'd0);
      expect_val("rst_rsbusyA", 64'd0);  expect_val("rst_rdC0", 64'd0);
      actQ.push_back(64'(readyA));  actQ.push_back(64'(readyC));
      actQ.push_back(64'(busyA));   actQ.push_back(rdA);
      actQ.push_back(64'(rsBusyA)); actQ.push_back(rdC[63:0]);
      reset_n = 1'b1;
      for (int edgeNo = 1; edgeNo <= 34; edgeNo++) begin
         @(posedge clk);
         #1;
         expect_val($sformatf("readyA_edge%0d", edgeNo), 64'(edgeNo >= 31));
         expect_val($sformatf("readyC_edge%0d", edgeNo), 64'(edgeNo >= 15));
         actQ.push_back(64'(readyA));
         actQ.push_back(64'(readyC));
         // late CLEAR-phase write/reserve to an already cleared register
         if (edgeNo >= 25 && edgeNo <= 28) begin
            wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hFFFF_FFFF;
            rsvEn = 1'b1; rsvAddr = 5'd4; rsAddr = {5'd3, 5'd3};
            #1;
            expect_val($sformatf("clear_rd_edge%0d", edgeNo), 64'd0);
            expect_val($sformatf("clear_rsbusy_edge%0d", edgeNo), 64'd0);
            actQ.push_back(rdA);
            actQ.push_back(64'(rsBusyA));
         end else begin
            idle_inputs();
         end
      end
      for (int r = 0; r < 32; r += 2) begin
         rsAddr = {5'(r + 1), 5'(r)};
         #1;
         expect_val($sformatf("zero_A_x%0d", r), 64'd0);
         expect_val($sformatf("zero_B_x%0d", r), 64'd0);
         actQ.push_back(rdA);
         actQ.push_back(rdB);
      end
      for (int r = 0; r < 16; r++) begin
         rsAddrC = {4'(r), 4'(r), 4'(r)};
         #1;
         expect_val($sformatf("zero_C_x%0d", r), 64'd0);
         actQ.push_back(rdC[63:0] | rdC[127:64] | rdC[191:128]);
      end
      expect_val("busy_after_clear", 64'd0);
      actQ.push_back(64'(busyA));
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); a = actQ.pop_front(); vectors++;
         if (a !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
         end
      end
   endtask

   task automatic test_write_read();
      exp_t        e;
      logic [63:0] a;
      @(negedge clk);
      wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'hDEAD_BEEF; rsAddr = {5'd5, 5'd5};
      expect_val("wr_sameA", 64'hDEADBEEF_DEADBEEF);
      expect_val("wr_sameB_old", 64'd0);
      #1;
      actQ.push_back(rdA);
      actQ.push_back(rdB);
      @(posedge clk);
      #1;
      idle_inputs();
      expect_val("wr_nextA", 64'hDEADBEEF_DEADBEEF);
      expect_val("wr_nextB", 64'hDEADBEEF_DEADBEEF);
      #1;
      actQ.push_back(rdA);
      actQ.push_back(rdB);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); a = actQ.pop_front(); vectors++;
         if (a !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
         end
      end
   endtask

   task automatic test_x0();
      exp_t        e;
      logic [63:0] a;
      @(negedge clk);
      wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'h0000_1234;
      rsvEn = 1'b1; rsvAddr = 5'd0; rsAddr = {5'd0, 5'd0};
      expect_val("x0_rdA", 64'd0);
      expect_val("x0_rsbusyA", 64'd0);
      #1;
      actQ.push_back(rdA);
      actQ.push_back(64'(rsBusyA));
      @(posedge clk);
      #1;
      idle_inputs();
      expect_val("x0_busyA", 64'd0);
      expect_val("x0_rdA_after", 64'd0);
      expect_val("x0_rsbusy_after", 64'd0);
      #1;
      actQ.push_back(64'(busyA));
      actQ.push_back(rdA);
      actQ.push_back(64'(rsBusyA));
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); a = actQ.pop_front(); vectors++;
         if (a !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
         end
      end
   endtask

   task automatic test_scoreboard();
      exp_t        e;
      logic [63:0] a;
      @(negedge clk);
      rsvEn = 1'b1; rsvAddr = 5'd7; rsAddr = {5'd5, 5'd7};
      expect_val("rsv7_before_edge", 64'd0);
      #1;
      actQ.push_back(64'(rsBusyA));
      @(posedge clk);
      #1;
      idle_inputs();
      expect_val("rsv7_busyA", 64'h80);
      expect_val("rsv7_rsbusyA", 64'b01);
      expect_val("rsv7_rsbusyB", 64'b01);
      #1;
      actQ.push_back(64'(busyA));
      actQ.push_back(64'(rsBusyA));
      actQ.push_back(64'(rsBusyB));
      // write to the reserved register: bypass hides busy on A only
      wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'h55;
      expect_val("wr7_rsbusyA", 64'b00);
      expect_val("wr7_rdA0", 64'h55);
      expect_val("wr7_rsbusyB", 64'b01);
      expect_val("wr7_rdB0", 64'd0);
      #1;
      actQ.push_back(64'(rsBusyA));
      actQ.push_back(64'(rdA[31:0]));
      actQ.push_back(64'(rsBusyB));
      actQ.push_back(64'(rdB[31:0]));
      @(posedge clk);
      #1;
      idle_inputs();
      expect_val("wr7_busy_cleared", 64'd0);
      expect_val("wr7_rdA_after", 64'h55);
      expect_val("wr7_rdB_after", 64'h55);
      #1;
      actQ.push_back(64'(busyA));
      actQ.push_back(64'(rdA[31:0]));
      actQ.push_back(64'(rdB[31:0]));
      // same-cycle reserve and write: data lands, reserve wins
      wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h55;
      rsvEn = 1'b1; rsvAddr = 5'd9; rsAddr = {5'd9, 5'd9};
      @(posedge clk);
      #1;
      idle_inputs();
      expect_val("rw9_busyA", 64'h200);
      expect_val("rw9_rdA", 64'h00000055_00000055);
      expect_val("rw9_rsbusyA", 64'b11);
      #1;
      actQ.push_back(64'(busyA));
      actQ.push_back(rdA);
      actQ.push_back(64'(rsBusyA));
      // reserve x7 twice in a row; second reservation of a busy register keeps it set
      rsvEn = 1'b1; rsvAddr = 5'd7;
      repeat (2) @(posedge clk);
      #1;
      idle_inputs();
      expect_val("busy_0x280_A", 64'h280);
      expect_val("busy_0x280_B", 64'h280);
      #1;
      actQ.push_back(64'(busyA));
      actQ.push_back(64'(busyB));
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); a = actQ.pop_front(); vectors++;
         if (a !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t        e;
      logic [63:0] a;
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      expect_val("mid_busyA", 64'd0);
      expect_val("mid_readyA", 64'd0);
      expect_val("mid_busyB", 64'd0);
      expect_val("mid_readyC", 64'd0);
      #1;
      actQ.push_back(64'(busyA));
      actQ.push_back(64'(readyA));
      actQ.push_back(64'(busyB));
      actQ.push_back(64'(readyC));
      #1;
      reset_n = 1'b1;
      for (int edgeNo = 1; edgeNo <= 32; edgeNo++) begin
         @(posedge clk);
         #1;
         expect_val($sformatf("mid_readyA_edge%0d", edgeNo), 64'(edgeNo >= 31));
         actQ.push_back(64'(readyA));
      end
      rsAddr = {5'd9, 5'd5};
      expect_val("mid_regs_cleared", 64'd0);
      #1;
      actQ.push_back(rdA);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); a = actQ.pop_front(); vectors++;
         if (a !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
         end
      end
   endtask

   task automatic test_sweep();
      exp_t        e;
      logic [63:0] a;
      logic [63:0] vals [3];
      logic [3:0]  addrs [3];
      vals  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001};
      addrs = '{4'd1, 4'd14, 4'd15};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wrEnC = 1'b1; wrAddrC = addrs[i]; wrDataC = vals[i];
      end
      @(negedge clk);
      idle_inputs();
      rsAddrC = {4'd14, 4'd1, 4'd15};
      expect_val("C_port0_x15", vals[2]);
      expect_val("C_port1_x1", vals[0]);
      expect_val("C_port2_x14", vals[1]);
      expect_val("C_rsbusy", 64'd0);
      #1;
      actQ.push_back(rdC[63:0]);
      actQ.push_back(rdC[127:64]);
      actQ.push_back(rdC[191:128]);
      actQ.push_back(64'(rsBusyC));
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); a = actQ.pop_front(); vectors++;
         if (a !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_x0();
      test_scoreboard();
      test_reset_mid();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, replacing the fixed 32×64 two-read-port file. It adds configurable width, depth and read-port count, a hardwired-zero x0, optional write-to-read bypass, and a per-register pending-write scoreboard. It also includes a post-reset clear sequencer, so the array can map to RAM without a parallel reset. It sits between decode (read addresses, reservations) and writeback (write port).

## Interface

Parameters:
- XLEN, 32: register width in bits.
- NREG, 32: number of registers; power of two, ≥4; AW = log2(NREG).
- NRD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports; 0 = reads see array contents only.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs_addr  in  NRD*AW  read addresses; port k = bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k = bits [k*XLEN +: XLEN].
- rs_busy  out  NRD  port k's register has a pending write.
- wr_en  in  1  write strobe (regWrite).
- wr_addr  in  AW  write address (rd).
- wr_data  in  XLEN  write data.
- rsv_en  in  1  reserve destination (instruction issued).
- rsv_addr  in  AW  register to reserve.
- busy_vec  out  NREG  scoreboard bits; bit 0 always 0.
- ready  out  1  clear sequence done; file accepts writes and reservations.

## Operation

- FSM states: CLEAR, READY.
  - reset_n low: state=CLEAR, idx=1, busy_vec=0, ready=0.
  - In CLEAR, each posedge writes 0 to reg[idx] and increments idx.
  - The edge that clears reg[NREG-1] moves the FSM to READY and sets ready=1.
  - READY is held until the next reset.
- In CLEAR: wr_en and rsv_en are ignored, all rd_data = 0, all rs_busy = 0.
- x0 has no storage; reads of address 0 return 0. Writes and reservations to address 0 are dropped.
- Write (READY, wr_en, wr_addr≠0): reg[wr_addr] ← wr_data at posedge; busy_vec[wr_addr] cleared at the same edge.
- Reserve (READY, rsv_en, rsv_addr≠0): busy_vec[rsv_addr] set at posedge. Reserving an already-busy register is legal; the bit stays 1.
- Reserve and write to the same address in the same cycle: the write updates data, and reserve wins, so the busy bit ends 1.
- Reads are combinational: rd_data[k] = reg[rs_addr[k]].
  - BYPASS=1 and READY, wr_en, wr_addr==rs_addr[k]≠0: rd_data[k] = wr_data, and rs_busy[k] = 0 for that cycle.
- rs_busy[k] = busy_vec[rs_addr[k]], with the bypass override above.
- Width rules: all data is XLEN bits; no extension or truncation; idx is AW bits.

## Timing

- Reset values:
  - rd_data = 0, rs_busy = 0, busy_vec = 0, ready = 0.
  - Array contents are undefined until the sequencer clears them.
- ready rises after exactly NREG-1 rising edges following reset_n deassertion; 31 edges for NREG=32.
- Write latency: data is visible on a non-bypassed read the cycle after the wr_en edge. With BYPASS=1 it is visible in the same cycle.
- Scoreboard latency: busy_vec updates one edge after rsv_en or wr_en.
- Reset asserted mid-operation (either state):
  - Asynchronous: ready and busy_vec drop immediately.
  - The clear sequence restarts from idx=1 on release.
  - Writes in flight are lost.

## Test plan

- Reset/clear, NREG=32:
  - Assert reset_n low for 3 cycles, release.
  - ready=0 for 30 edges and =1 after edge 31.
  - Every register reads 0.
  - wr_en pulsed during CLEAR has no effect.
- Write/read, XLEN=32:
  - Write x5=0xDEADBEEF, then read x5 on all NRD ports.
  - The value appears next cycle; with BYPASS=1 it appears the same cycle.
  - With BYPASS=0, the same-cycle read returns the old value (0).
- x0:
  - Write 0x1234 to x0 and reserve x0.
  - x0 reads 0; busy_vec[0]=0; rs_busy=0.
- Scoreboard:
  - Reserve x7: busy_vec[7]=1 next cycle and rs_busy=1 on a port reading x7.
  - Write x7=0x55: busy clears on that edge.
  - Reserve and write x9 in the same cycle: data is 0x55 and busy_vec[9]=1.
- Reset mid-operation:
  - With busy_vec=0x0000_0280 in READY, pulse reset_n low between clock edges.
  - busy_vec=0 and ready=0 immediately.
  - ready returns after 31 edges.
- Parameter sweep:
  - NREG=16, NRD=3, XLEN=64: ready after 15 edges.
  - Three distinct simultaneous reads return correct 64-bit values.
